// File: rtl/bsg_counter_window_sched_pkg.sv
// Shared types for the windowed event-counter scheduler.
package bsg_counter_window_sched_pkg;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eClear = 2'd1,
    eCount = 2'd2,
    eOut   = 2'd3
  } state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Clear/up event counter with synchronous reset; a same-cycle clear and up
// restarts the count at one.
module bsg_counter_clear_up #(
  parameter longint unsigned max_val_p  = 64'd15,
  parameter longint unsigned init_val_p = 64'd0,
  localparam int ptr_width_lp = $clog2(max_val_p + 64'd1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  logic [ptr_width_lp-1:0] count_r;

  // Counter state update: reset, clear (folding in up), or increment.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= ptr_width_lp'(init_val_p);
    end else if (clear_i) begin
      count_r <= {{(ptr_width_lp-1){1'b0}}, up_i};
    end else if (up_i) begin
      count_r <= count_r + {{(ptr_width_lp-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_counter_window_sched.sv
// Round-robin scheduler sharing one saturating clear/up counter across
// num_chan_p event channels, one programmable-length window per channel.
module bsg_counter_window_sched
  import bsg_counter_window_sched_pkg::*;
#(
  parameter int num_chan_p  = 4,
  parameter int width_p     = 24,
  parameter int win_width_p = 16,
  localparam int chan_width_lp = $clog2(num_chan_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [win_width_p-1:0]   win_len_i,
  input  logic [num_chan_p-1:0]    event_i,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic [width_p-1:0]       count_o,
  output logic [chan_width_lp-1:0] chan_o,
  output logic                     busy_o
);

  state_e                   state_r;
  logic [chan_width_lp-1:0] chan_r;
  logic [win_width_p-1:0]   win_cnt_r;
  logic                     v_r;
  logic                     busy_r;
  logic [width_p-1:0]       count_r;

  logic                     clear_s;
  logic                     up_s;
  logic                     sat_s;
  logic [width_p-1:0]       ctr_val_s;
  logic [width_p-1:0]       ctr_next_s;
  logic [win_width_p-1:0]   win_load_s;
  logic [chan_width_lp-1:0] chan_next_s;

  bsg_counter_clear_up #(
    .max_val_p  ((64'd1 << width_p) - 64'd1),
    .init_val_p (64'd0)
  ) counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_s),
    .up_i    (up_s),
    .count_o (ctr_val_s)
  );

  // Counter controls, saturation gate, window reload value and next channel.
  always_comb begin
    clear_s = 1'b0;
    up_s    = 1'b0;
    sat_s   = (ctr_val_s == {width_p{1'b1}});
    case (state_r)
      eClear:  clear_s = 1'b1;
      eCount:  up_s    = event_i[chan_r] & ~sat_s;
      default: begin
        clear_s = 1'b0;
        up_s    = 1'b0;
      end
    endcase
    // A zero length is treated as a one-cycle window.
    if (win_len_i == {win_width_p{1'b0}}) begin
      win_load_s = {win_width_p{1'b0}};
    end else begin
      win_load_s = win_len_i - {{(win_width_p-1){1'b0}}, 1'b1};
    end
    if (chan_r == chan_width_lp'(num_chan_p - 1)) begin
      chan_next_s = {chan_width_lp{1'b0}};
    end else begin
      chan_next_s = chan_r + {{(chan_width_lp-1){1'b0}}, 1'b1};
    end
    ctr_next_s = ctr_val_s + {{(width_p-1){1'b0}}, up_s};
  end

  // Window FSM with registered result, valid and busy outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= eIdle;
      chan_r    <= {chan_width_lp{1'b0}};
      win_cnt_r <= {win_width_p{1'b0}};
      v_r       <= 1'b0;
      busy_r    <= 1'b0;
      count_r   <= {width_p{1'b0}};
    end else begin
      case (state_r)
        eIdle: begin
          if (en_i) begin
            state_r <= eClear;
            busy_r  <= 1'b1;
          end else begin
            state_r <= eIdle;
            busy_r  <= 1'b0;
          end
        end
        eClear: begin
          win_cnt_r <= win_load_s;
          state_r   <= eCount;
        end
        eCount: begin
          // Capture includes the final cycle's increment.
          if (win_cnt_r == {win_width_p{1'b0}}) begin
            state_r <= eOut;
            v_r     <= 1'b1;
            count_r <= ctr_next_s;
          end else begin
            win_cnt_r <= win_cnt_r - {{(win_width_p-1){1'b0}}, 1'b1};
          end
        end
        eOut: begin
          if (ready_i) begin
            v_r    <= 1'b0;
            chan_r <= chan_next_s;
            if (en_i) begin
              state_r <= eClear;
              busy_r  <= 1'b1;
            end else begin
              state_r <= eIdle;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= eIdle;
          busy_r  <= 1'b0;
          v_r     <= 1'b0;
        end
      endcase
    end
  end

  assign v_o     = v_r;
  assign count_o = count_r;
  assign chan_o  = chan_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_bsg_counter_window_sched.sv
// Directed-vector bench for bsg_counter_window_sched: a default instance and a
// 4-bit-counter instance for the saturation boundary.
module tb_bsg_counter_window_sched;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en, en_s, ready;
  logic [15:0] win_len;
  logic [3:0]  ev, ev_s;
  logic        v, busy, v_s, busy_s;
  logic [23:0] cnt;
  logic [3:0]  cnt_s;
  logic [1:0]  chan, chan_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsg_counter_window_sched #(.num_chan_p(4), .width_p(24), .win_width_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en), .win_len_i(win_len), .event_i(ev),
    .v_o(v), .ready_i(ready), .count_o(cnt), .chan_o(chan), .busy_o(busy)
  );

  bsg_counter_window_sched #(.num_chan_p(4), .width_p(4), .win_width_p(16)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_s), .win_len_i(win_len), .event_i(ev_s),
    .v_o(v_s), .ready_i(ready), .count_o(cnt_s), .chan_o(chan_s), .busy_o(busy_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; en = 1'b0; en_s = 1'b0; ready = 1'b0; ev = 4'h0; ev_s = 4'h0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic wait_v(input int limit, output int n);
    n = 0;
    while (v !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0; en = 1'b0; en_s = 1'b0; ready = 1'b0; ev = 4'h0; ev_s = 4'h0;
    win_len = 16'd1;
    #3 reset_i = 1'b1;
    #1;
    total++; if (v !== 1'b0)     begin bad++; $display("FAIL reset_v: got %0b want 0", v); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (cnt !== 24'd0)  begin bad++; $display("FAIL reset_count: got %0d want 0", cnt); end
    total++; if (chan !== 2'd0)  begin bad++; $display("FAIL reset_chan: got %0d want 0", chan); end
    tick();
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (busy !== 1'b0 || v !== 1'b0)
        begin bad++; $display("FAIL idle_%0d: got busy=%0b v=%0b want 0 0", i, busy, v); end
    end
  endtask

  task automatic test_basic_window();
    logic [7:0] pat;
    pat = 8'b1011_0101;
    do_reset();
    win_len = 16'd8; en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
    tick();
    for (int i = 0; i < 8; i++) begin
      ev = {3'b111, pat[i]};
      if (i == 7) begin
        total++; if (v !== 1'b0) begin bad++; $display("FAIL basic_early_v: got %0b want 0", v); end
      end
      tick();
    end
    ev = 4'h0;
    total++; if (v !== 1'b1)    begin bad++; $display("FAIL basic_v: got %0b want 1", v); end
    total++; if (cnt !== 24'd5) begin bad++; $display("FAIL basic_count: got %0d want 5", cnt); end
    total++; if (chan !== 2'd0) begin bad++; $display("FAIL basic_chan: got %0d want 0", chan); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if (v !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL basic_idle: got v=%0b busy=%0b want 0 0", v, busy); end
    total++; if (chan !== 2'd1) begin bad++; $display("FAIL basic_chan_adv: got %0d want 1", chan); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    win_len = 16'd4; ev = 4'hF; ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_v(20, n);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL rr_v_%0d: got %0b want 1", k, v); end
      total++; if (n != ((k == 0) ? 6 : 5))
        begin bad++; $display("FAIL rr_latency_%0d: got %0d want %0d", k, n, (k == 0) ? 6 : 5); end
      total++; if (chan !== 2'(k % 4))
        begin bad++; $display("FAIL rr_chan_%0d: got %0d want %0d", k, chan, k % 4); end
      total++; if (cnt !== 24'd4) begin bad++; $display("FAIL rr_count_%0d: got %0d want 4", k, cnt); end
      tick();
      total++; if (v !== 1'b0 || busy !== 1'b1)
        begin bad++; $display("FAIL rr_clear_%0d: got v=%0b busy=%0b want 0 1", k, v, busy); end
    end
    en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_drain: got busy=%0b want 0", busy); end
    ready = 1'b0; ev = 4'h0;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    win_len = 16'd3; ev = 4'b0001; en = 1'b1;
    tick();
    en = 1'b0;
    wait_v(20, n);
    total++; if (v !== 1'b1)    begin bad++; $display("FAIL bp_v: got %0b want 1", v); end
    for (int i = 0; i < 15; i++) begin
      ev = (i % 2 == 0) ? 4'hF : 4'h0;
      tick();
      total++; if (v !== 1'b1 || cnt !== 24'd3 || chan !== 2'd0)
        begin bad++; $display("FAIL bp_hold_%0d: got v=%0b cnt=%0d chan=%0d want 1 3 0", i, v, cnt, chan); end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if (v !== 1'b0 || chan !== 2'd1)
      begin bad++; $display("FAIL bp_release: got v=%0b chan=%0d want 0 1", v, chan); end
    win_len = 16'd2; ev = 4'b0010; en = 1'b1;
    tick();
    en = 1'b0;
    wait_v(20, n);
    total++; if (cnt !== 24'd2 || chan !== 2'd1)
      begin bad++; $display("FAIL bp_chan1: got cnt=%0d chan=%0d want 2 1", cnt, chan); end
    #2 reset_i = 1'b1;
    #1;
    total++; if (v !== 1'b0 || busy !== 1'b0 || cnt !== 24'd0 || chan !== 2'd0)
      begin bad++; $display("FAIL async_rst_out: got v=%0b busy=%0b cnt=%0d chan=%0d want 0 0 0 0", v, busy, cnt, chan); end
    tick();
    reset_i = 1'b0; ev = 4'h0;
  endtask

  task automatic test_boundary();
    int n;
    do_reset();
    win_len = 16'd0; ev = 4'b0001; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    total++; if (v !== 1'b0) begin bad++; $display("FAIL len0_early: got %0b want 0", v); end
    tick();
    total++; if (v !== 1'b1 || cnt !== 24'd1)
      begin bad++; $display("FAIL len0_one: got v=%0b cnt=%0d want 1 1", v, cnt); end
    ready = 1'b1;
    tick();
    ready = 1'b0; ev = 4'b1101; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    total++; if (v !== 1'b1 || cnt !== 24'd0 || chan !== 2'd1)
      begin bad++; $display("FAIL len0_zero: got v=%0b cnt=%0d chan=%0d want 1 0 1", v, cnt, chan); end
    ready = 1'b1;
    tick();
    ready = 1'b0; ev = 4'h0;
    win_len = 16'd40; ev_s = 4'b0001; en_s = 1'b1;
    tick();
    en_s = 1'b0;
    n = 1;
    while (v_s !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    total++; if (v_s !== 1'b1 || n != 42)
      begin bad++; $display("FAIL sat_latency: got v=%0b n=%0d want 1 42", v_s, n); end
    total++; if (cnt_s !== 4'd15 || chan_s !== 2'd0)
      begin bad++; $display("FAIL sat_count: got cnt=%0d chan=%0d want 15 0", cnt_s, chan_s); end
    ready = 1'b1;
    tick();
    ready = 1'b0; ev_s = 4'h0;
    total++; if (v_s !== 1'b0 || busy_s !== 1'b0)
      begin bad++; $display("FAIL sat_done: got v=%0b busy=%0b want 0 0", v_s, busy_s); end
  endtask

  task automatic test_mid_op();
    int n;
    do_reset();
    win_len = 16'd6; ev = 4'b0001; ready = 1'b1; en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0; win_len = 16'd20;
    wait_v(20, n);
    total++; if (v !== 1'b1 || cnt !== 24'd6 || chan !== 2'd0)
      begin bad++; $display("FAIL en_drop: got v=%0b cnt=%0d chan=%0d want 1 6 0", v, cnt, chan); end
    tick();
    total++; if (busy !== 1'b0 || v !== 1'b0 || chan !== 2'd1)
      begin bad++; $display("FAIL en_drop_idle: got busy=%0b v=%0b chan=%0d want 0 0 1", busy, v, chan); end
    win_len = 16'd6; en = 1'b1;
    tick();
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || chan !== 2'd0)
      begin bad++; $display("FAIL rst_count: got busy=%0b chan=%0d want 0 0", busy, chan); end
    tick();
    reset_i = 1'b0; win_len = 16'd2; ev = 4'b0001;
    wait_v(20, n);
    total++; if (v !== 1'b1 || cnt !== 24'd2 || chan !== 2'd0)
      begin bad++; $display("FAIL rst_restart: got v=%0b cnt=%0d chan=%0d want 1 2 0", v, cnt, chan); end
    en = 1'b0;
    tick();
    ready = 1'b0; ev = 4'h0;
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
